// File: rtl/dap_swo_pkg.sv
// rtl/dap_swo_pkg.sv - shared constants and types for the SWO UART receiver
package dap_swo_pkg;

  // Register word offsets from BASE_ADDR
  localparam int unsigned REG_CR     = 0;
  localparam int unsigned REG_STATUS = 1;
  localparam int unsigned REG_DATA   = 2;

  // STATUS bit positions
  localparam int unsigned STAT_OVF_BIT  = 16;
  localparam int unsigned STAT_FERR_BIT = 17;
  localparam int unsigned STAT_BUSY_BIT = 18;

  // Receiver state encoding
  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_START_ENC = 2'd1;
  localparam logic [1:0] ST_DATA_ENC  = 2'd2;
  localparam logic [1:0] ST_STOP_ENC  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE_ENC,
    S_START = ST_START_ENC,
    S_DATA  = ST_DATA_ENC,
    S_STOP  = ST_STOP_ENC
  } rx_state_t;

  // Smallest usable bit divider; below this the half-bit start delay collapses
  localparam logic [15:0] MIN_DIV = 16'd3;

  function automatic logic [15:0] eff_div(input logic [15:0] baud_div);
    return (baud_div < MIN_DIV) ? MIN_DIV : baud_div;
  endfunction

endpackage

// File: rtl/swo_byte_fifo.sv
// rtl/swo_byte_fifo.sv - single-clock byte FIFO with flush and occupancy count
module swo_byte_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   i_push,
  input  logic [7:0]             i_push_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   o_not_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [7:0]             o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_not_empty;

  logic          w_pop_ok;
  logic          w_push_ok;
  logic [CW-1:0] w_count_next;

  assign o_full      = (r_count == CW'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_not_empty = r_not_empty;
  assign o_count     = r_count;
  assign o_head      = r_mem[r_rd_ptr];

  // A full FIFO still takes a push when a pop frees the head slot in the same cycle
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // Next occupancy; simultaneous push and pop cancel out
  always_comb begin
    w_count_next = r_count;
    if (w_push_ok && !w_pop_ok) begin
      w_count_next = r_count + 1'b1;
    end else if (w_pop_ok && !w_push_ok) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // Storage array, written on accepted pushes unless a flush is in progress
  always_ff @(posedge clk) begin
    if (w_push_ok && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers and count; flush has priority over any push or pop
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_not_empty <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_not_empty <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count     <= w_count_next;
      r_not_empty <= (w_count_next != '0);
    end
  end

endmodule

// File: rtl/dap_swo_uart_rx.sv
// rtl/dap_swo_uart_rx.sv - oversampling 8N1 SWO receiver with register-mapped FIFO
module dap_swo_uart_rx
  import dap_swo_pkg::*;
#(
  parameter int          ADDRWIDTH  = 12,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int          FIFO_DEPTH = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 ahb_write_en,
  input  logic                 ahb_read_en,
  input  logic [ADDRWIDTH-1:0] ahb_addr,
  input  logic [31:0]          ahb_wdata,
  input  logic [3:0]           ahb_byte_strobe,
  output logic [31:0]          ahb_rdata,
  input  logic                 swo_i,
  output logic                 swo_data_avail
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDRWIDTH-1:0] BASE_A = ADDRWIDTH'(BASE_ADDR);
  localparam logic [ADDRWIDTH-3:0] BASE_W = BASE_A[ADDRWIDTH-1:2];

  logic            r_swo_meta;
  logic            r_swo_sync;
  logic            r_en;
  logic [15:0]     r_baud_div;
  logic            r_ovf;
  logic            r_ferr;
  rx_state_t       r_state;
  rx_state_t       w_state_next;
  logic [15:0]     r_timer;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_armed;

  logic [ADDRWIDTH-3:0] w_word_ofs;
  logic            w_sel_cr;
  logic            w_sel_status;
  logic            w_sel_data;
  logic [15:0]     w_div;
  logic            w_expire;
  logic            w_load_half;
  logic            w_load_full;
  logic            w_shift_en;
  logic            w_push_req;
  logic            w_ferr_set;
  logic            w_armed_clr;
  logic            w_flush;
  logic            w_pop;
  logic            w_stat_wr;
  logic            w_ovf_set;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic            w_fifo_not_empty;
  logic [CW-1:0]   w_fifo_count;
  logic [7:0]      w_fifo_head;
  logic            w_unused_inputs;

  assign w_unused_inputs = &{1'b0, ahb_addr[1:0], ahb_wdata[15:2], ahb_byte_strobe[1]};

  assign w_word_ofs   = ahb_addr[ADDRWIDTH-1:2] - BASE_W;
  assign w_sel_cr     = (w_word_ofs == (ADDRWIDTH-2)'(REG_CR));
  assign w_sel_status = (w_word_ofs == (ADDRWIDTH-2)'(REG_STATUS));
  assign w_sel_data   = (w_word_ofs == (ADDRWIDTH-2)'(REG_DATA));

  assign w_div    = eff_div(r_baud_div);
  assign w_expire = (r_timer == '0);

  assign w_flush   = ahb_write_en && w_sel_cr && ahb_byte_strobe[0] && ahb_wdata[1];
  assign w_pop     = ahb_read_en && w_sel_data && !w_fifo_empty;
  assign w_stat_wr = ahb_write_en && w_sel_status && ahb_byte_strobe[2];
  assign w_ovf_set = w_push_req && w_fifo_full && !w_pop && !w_flush;

  assign swo_data_avail = w_fifo_not_empty;

  // Two-flop synchroniser; idles high so reset does not look like a start bit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_swo_meta <= 1'b1;
      r_swo_sync <= 1'b1;
    end else begin
      r_swo_meta <= swo_i;
      r_swo_sync <= r_swo_meta;
    end
  end

  // Control register; FLUSH is not stored, it acts only during the write cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_en       <= 1'b0;
      r_baud_div <= '0;
    end else if (ahb_write_en && w_sel_cr) begin
      if (ahb_byte_strobe[0]) r_en             <= ahb_wdata[0];
      if (ahb_byte_strobe[2]) r_baud_div[7:0]  <= ahb_wdata[23:16];
      if (ahb_byte_strobe[3]) r_baud_div[15:8] <= ahb_wdata[31:24];
    end
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ovf  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (w_ovf_set)                       r_ovf <= 1'b1;
      else if (w_stat_wr && ahb_wdata[16]) r_ovf <= 1'b0;
      if (w_ferr_set)                       r_ferr <= 1'b1;
      else if (w_stat_wr && ahb_wdata[17])  r_ferr <= 1'b0;
    end
  end

  // Receiver state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Receiver next-state and per-cycle actions
  always_comb begin
    w_state_next = r_state;
    w_load_half  = 1'b0;
    w_load_full  = 1'b0;
    w_shift_en   = 1'b0;
    w_push_req   = 1'b0;
    w_ferr_set   = 1'b0;
    w_armed_clr  = 1'b0;
    if (!r_en) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_armed && !r_swo_sync) begin
            w_state_next = S_START;
            w_load_half  = 1'b1;
          end
        end
        S_START: begin
          if (w_expire) begin
            if (!r_swo_sync) begin
              w_state_next = S_DATA;
              w_load_full  = 1'b1;
            end else begin
              w_state_next = S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (w_expire) begin
            w_shift_en  = 1'b1;
            w_load_full = 1'b1;
            if (r_bit_idx == 3'd7) w_state_next = S_STOP;
          end
        end
        S_STOP: begin
          if (w_expire) begin
            w_state_next = S_IDLE;
            if (r_swo_sync) begin
              w_push_req = 1'b1;
            end else begin
              w_ferr_set  = 1'b1;
              w_armed_clr = 1'b1;
            end
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Bit timer, bit index, shift register and re-arm flag after a framing error
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_armed   <= 1'b0;
    end else begin
      if (w_load_half)         r_timer <= w_div >> 1;
      else if (w_load_full)    r_timer <= w_div;
      else if (!w_expire)      r_timer <= r_timer - 1'b1;

      if (r_state != S_DATA)   r_bit_idx <= '0;
      else if (w_shift_en)     r_bit_idx <= r_bit_idx + 1'b1;

      if (w_shift_en)          r_shift[r_bit_idx] <= r_swo_sync;

      if (w_armed_clr)         r_armed <= 1'b0;
      else if (r_swo_sync)     r_armed <= 1'b1;
    end
  end

  // Register read mux; unmapped addresses read as X
  always_comb begin
    ahb_rdata = 'x;
    if (w_sel_cr) begin
      ahb_rdata = {r_baud_div, 15'b0, r_en};
    end else if (w_sel_status) begin
      ahb_rdata = {13'b0, (r_state != S_IDLE), r_ferr, r_ovf, 16'(w_fifo_count)};
    end else if (w_sel_data) begin
      ahb_rdata = w_fifo_empty ? 32'h0 : {23'b0, 1'b1, w_fifo_head};
    end
  end

  swo_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .i_push      (w_push_req),
    .i_push_data (r_shift),
    .i_pop       (w_pop),
    .i_flush     (w_flush),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_not_empty (w_fifo_not_empty),
    .o_count     (w_fifo_count),
    .o_head      (w_fifo_head)
  );

endmodule

// File: tb/tb_dap_swo_uart_rx.sv
// tb/tb_dap_swo_uart_rx.sv - scoreboard bench for the SWO UART receiver
module tb_dap_swo_uart_rx;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ahb_write_en = 1'b0;
  logic        ahb_read_en = 1'b0;
  logic [11:0] ahb_addr = '0;
  logic [31:0] ahb_wdata = '0;
  logic [3:0]  ahb_byte_strobe = '0;
  logic [31:0] ahb_rdata;
  logic        swo_i = 1'b1;
  logic        swo_data_avail;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  sb_q[$];
  logic        model_ovf = 1'b0;
  logic        model_ferr = 1'b0;

  dap_swo_uart_rx #(
    .ADDRWIDTH  (12),
    .BASE_ADDR  (0),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .ahb_write_en    (ahb_write_en),
    .ahb_read_en     (ahb_read_en),
    .ahb_addr        (ahb_addr),
    .ahb_wdata       (ahb_wdata),
    .ahb_byte_strobe (ahb_byte_strobe),
    .ahb_rdata       (ahb_rdata),
    .swo_i           (swo_i),
    .swo_data_avail  (swo_data_avail)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic reg_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb);
    @(negedge clk);
    ahb_addr        = addr;
    ahb_wdata       = data;
    ahb_byte_strobe = strb;
    ahb_write_en    = 1'b1;
    @(negedge clk);
    ahb_write_en    = 1'b0;
    ahb_byte_strobe = '0;
  endtask

  task automatic reg_read(input logic [11:0] addr, output logic [31:0] data);
    @(negedge clk);
    ahb_addr    = addr;
    ahb_read_en = 1'b1;
    #1;
    data = ahb_rdata;
    @(negedge clk);
    ahb_read_en = 1'b0;
  endtask

  // Model of a received byte arriving at the FIFO
  task automatic sb_push(input logic [7:0] b);
    if (sb_q.size() < DEPTH) sb_q.push_back(b);
    else model_ovf = 1'b1;
  endtask

  task automatic check_status(input string tag, input logic busy);
    logic [31:0] d;
    reg_read(12'h004, d);
    check_val(tag, d, {13'b0, busy, model_ferr, model_ovf, 16'(sb_q.size())});
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] d;
    logic [31:0] exp;
    exp = 32'h0;
    if (sb_q.size() != 0) exp = {23'b0, 1'b1, sb_q.pop_front()};
    reg_read(12'h008, d);
    check_val(tag, d, exp);
  endtask

  // Drives one 8N1 frame; must be entered just after a falling clock edge
  task automatic send_byte(input logic [7:0] b, input int bit_cyc, input logic stop_val, input int stop_cyc);
    swo_i = 1'b0;
    repeat (bit_cyc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      swo_i = b[i];
      repeat (bit_cyc) @(negedge clk);
    end
    swo_i = stop_val;
    repeat (stop_cyc) @(negedge clk);
    swo_i = 1'b1;
    repeat (bit_cyc) @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;

    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Reset state
    reg_read(12'h000, d);
    check_val("rst_cr", d, 32'h0);
    check_status("rst_status", 1'b0);
    check_val("rst_avail", {31'b0, swo_data_avail}, 32'h0);
    pop_check("rst_data");

    // Basic frame at 10 clk/bit
    reg_write(12'h000, 32'h0009_0001, 4'hF);
    send_byte(8'hA5, 10, 1'b1, 10);
    sb_push(8'hA5);
    check_status("basic_status", 1'b0);
    check_val("basic_avail", {31'b0, swo_data_avail}, 32'h1);
    pop_check("basic_data");
    pop_check("basic_empty_data");
    check_status("basic_status_after", 1'b0);
    check_val("basic_avail_after", {31'b0, swo_data_avail}, 32'h0);

    // Short low glitch on an idle line is rejected without a flag
    swo_i = 1'b0;
    repeat (3) @(negedge clk);
    swo_i = 1'b1;
    repeat (20) @(negedge clk);
    check_status("glitch_status", 1'b0);

    // Framing error with an extended break, then clear FERR
    send_byte(8'h3C, 10, 1'b0, 40);
    model_ferr = 1'b1;
    check_status("ferr_status", 1'b0);
    reg_write(12'h004, 32'h0002_0000, 4'b0100);
    model_ferr = 1'b0;
    check_status("ferr_cleared", 1'b0);

    // Overflow: five bytes into a four-deep FIFO
    for (int i = 1; i <= 5; i++) begin
      send_byte(8'(i), 10, 1'b1, 10);
      sb_push(8'(i));
    end
    check_status("ovf_status", 1'b0);
    for (int i = 0; i < 4; i++) pop_check("ovf_data");
    pop_check("ovf_drained");
    reg_write(12'h004, 32'h0001_0000, 4'b0100);
    model_ovf = 1'b0;
    check_status("ovf_cleared", 1'b0);

    // Full FIFO: pop lands on the same edge as the fifth push
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h11 + 8'(i), 10, 1'b1, 10);
      sb_push(8'h11 + 8'(i));
    end
    fork
      send_byte(8'h15, 10, 1'b1, 10);
      begin
        repeat (97) @(posedge clk);
        pop_check("simul_pop");
      end
    join
    sb_push(8'h15);
    check_status("simul_status", 1'b0);
    for (int i = 0; i < 4; i++) pop_check("simul_data");

    // EN dropped during data bit 4 aborts the frame
    fork
      send_byte(8'h77, 10, 1'b1, 10);
      begin
        repeat (50) @(posedge clk);
        check_status("en_busy", 1'b1);
        reg_write(12'h000, 32'h0009_0000, 4'b0001);
        check_status("en_idle", 1'b0);
      end
    join
    check_status("en_no_push", 1'b0);
    reg_write(12'h000, 32'h0009_0001, 4'b0001);

    // FLUSH with three bytes queued and a push on the same edge
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h21 + 8'(i), 10, 1'b1, 10);
      sb_push(8'h21 + 8'(i));
    end
    check_status("flush_pre", 1'b0);
    fork
      send_byte(8'h24, 10, 1'b1, 10);
      begin
        repeat (97) @(posedge clk);
        reg_write(12'h000, 32'h0009_0003, 4'b0001);
      end
    join
    sb_q.delete();
    check_status("flush_status", 1'b0);
    pop_check("flush_data");
    reg_read(12'h000, d);
    check_val("flush_cr", d, 32'h0009_0001);

    // Reset in the middle of a frame
    send_byte(8'h31, 10, 1'b1, 10);
    sb_push(8'h31);
    fork
      send_byte(8'h32, 10, 1'b1, 10);
      begin
        repeat (40) @(posedge clk);
        @(negedge clk);
        resetn   = 1'b0;
        ahb_addr = 12'h004;
        #1;
        check_val("rst_mid_status", ahb_rdata, 32'h0);
        check_val("rst_mid_avail", {31'b0, swo_data_avail}, 32'h0);
        ahb_addr = 12'h000;
        #1;
        check_val("rst_mid_cr", ahb_rdata, 32'h0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
      end
    join
    sb_q.delete();
    model_ovf  = 1'b0;
    model_ferr = 1'b0;
    check_status("rst_mid_after", 1'b0);

    // Divider clamp: BAUD_DIV=1 runs at 4 clk/bit
    reg_write(12'h000, 32'h0001_0001, 4'hF);
    send_byte(8'h55, 4, 1'b1, 4);
    sb_push(8'h55);
    send_byte(8'hC3, 4, 1'b1, 4);
    sb_push(8'hC3);
    check_status("clamp_status", 1'b0);
    pop_check("clamp_data0");
    pop_check("clamp_data1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
